// File: rtl/conv_channel_accumulator.sv
// Per-pixel channel accumulator behind the conv adder tree: saturating sign-magnitude sum + bias.
// Optional ReLU on the output value when CONV_ACC_RELU_EN is defined.
module conv_channel_accumulator #(
  parameter int DATA_WIDTH   = 32,
  parameter int FRAC_WIDTH   = 15,
  parameter int MAX_CHANNELS = 64,
  localparam int CNT_W       = $clog2(MAX_CHANNELS + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_start,
  input  logic [CNT_W-1:0]      i_num_channels,
  input  logic [DATA_WIDTH-1:0] i_bias,
  input  logic [DATA_WIDTH-1:0] i_tree_data,
  input  logic                  i_tree_overflow,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_out_ready,
  output logic                  o_overflow,
  output logic                  o_busy
);

  localparam int MAG_W = DATA_WIDTH - 1;

  if (FRAC_WIDTH >= DATA_WIDTH) begin : g_bad_frac
    $error("FRAC_WIDTH must be smaller than DATA_WIDTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_BIAS, S_OUT} state_t;

  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_acc, r_bias, r_data;
  logic [CNT_W-1:0]      r_count, r_num;
  logic                  r_ovf;
  logic [DATA_WIDTH-1:0] w_operand;
  logic [DATA_WIDTH:0]   w_sum;
  logic                  w_last;

  // Returns {overflow, sign, magnitude}; never produces a negative zero.
  function automatic logic [DATA_WIDTH:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
    logic [MAG_W:0]   s;
    logic [MAG_W-1:0] m;
    logic             sg;
    logic             ov;
    s  = '0;
    ov = 1'b0;
    if (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) begin
      s  = {1'b0, a[MAG_W-1:0]} + {1'b0, b[MAG_W-1:0]};
      ov = s[MAG_W];
      m  = ov ? '1 : s[MAG_W-1:0];
      sg = a[DATA_WIDTH-1];
    end else if (a[MAG_W-1:0] >= b[MAG_W-1:0]) begin
      m  = a[MAG_W-1:0] - b[MAG_W-1:0];
      sg = a[DATA_WIDTH-1];
    end else begin
      m  = b[MAG_W-1:0] - a[MAG_W-1:0];
      sg = b[DATA_WIDTH-1];
    end
    if (m == '0) sg = 1'b0;
    return {ov, sg, m};
  endfunction

  assign w_operand = (r_state == S_BIAS) ? r_bias : i_tree_data;
  assign w_sum     = sat_add(r_acc, w_operand);
  assign w_last    = (r_count == r_num - CNT_W'(1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_enable) begin
      case (r_state)
        S_IDLE:  if (i_start) w_next = S_ACCUM;
        S_ACCUM: if (i_valid && w_last) w_next = S_BIAS;
        S_BIAS:  w_next = S_OUT;
        S_OUT:   if (i_out_ready) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_ready = (r_state == S_ACCUM) && i_enable;
    o_valid = (r_state == S_OUT);
    o_busy  = (r_state != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_acc   <= '0;
      r_bias  <= '0;
      r_data  <= '0;
      r_count <= '0;
      r_num   <= '0;
      r_ovf   <= 1'b0;
    end else if (i_enable) begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_acc   <= '0;
          r_count <= '0;
          r_ovf   <= 1'b0;
          r_bias  <= i_bias;
          r_num   <= (i_num_channels == '0) ? CNT_W'(1) : i_num_channels;
        end
        S_ACCUM: if (i_valid) begin
          r_acc   <= w_sum[DATA_WIDTH-1:0];
          r_count <= r_count + CNT_W'(1);
          r_ovf   <= r_ovf | i_tree_overflow | w_sum[DATA_WIDTH];
        end
        S_BIAS: begin
          r_acc <= w_sum[DATA_WIDTH-1:0];
          r_ovf <= r_ovf | w_sum[DATA_WIDTH];
`ifdef CONV_ACC_RELU_EN
          r_data <= w_sum[DATA_WIDTH-1] ? '0 : w_sum[DATA_WIDTH-1:0];
`else
          r_data <= w_sum[DATA_WIDTH-1:0];
`endif
        end
        default: ;
      endcase
    end
  end

  assign o_data     = r_data;
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_conv_channel_accumulator.sv
// Directed self-checking bench for conv_channel_accumulator (DATA_WIDTH=32, FRAC_WIDTH=15).
module tb_conv_channel_accumulator;
  localparam int CNT_W = 7;

  logic             i_clk = 1'b0;
  logic             i_reset = 1'b1;
  logic             i_enable = 1'b1;
  logic             i_start = 1'b0;
  logic [CNT_W-1:0] i_num_channels = '0;
  logic [31:0]      i_bias = '0;
  logic [31:0]      i_tree_data = '0;
  logic             i_tree_overflow = 1'b0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [31:0]      o_data;
  logic             o_valid;
  logic             i_out_ready = 1'b0;
  logic             o_overflow;
  logic             o_busy;

  int checks = 0;
  int failures = 0;

  conv_channel_accumulator #(.DATA_WIDTH(32), .FRAC_WIDTH(15), .MAX_CHANNELS(64)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_start(i_start),
    .i_num_channels(i_num_channels), .i_bias(i_bias), .i_tree_data(i_tree_data),
    .i_tree_overflow(i_tree_overflow), .i_valid(i_valid), .o_ready(o_ready),
    .o_data(o_data), .o_valid(o_valid), .i_out_ready(i_out_ready),
    .o_overflow(o_overflow), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Starts a pixel at cycle 0, streams sums back-to-back, waits (bounded) for o_valid.
  task automatic run_pixel(input int nsum, input logic [CNT_W-1:0] ncfg, input logic [31:0] bias,
                           input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [2:0] ov, output int lat, output bit tmo);
    logic [31:0] d [3];
    int cyc;
    d[0] = d0; d[1] = d1; d[2] = d2;
    i_num_channels = ncfg;
    i_bias = bias;
    i_start = 1'b1;
    cyc = 0;
    for (int k = 0; k < nsum; k++) begin
      step(); cyc++;
      i_start = 1'b0;
      i_valid = 1'b1;
      i_tree_data = d[k];
      i_tree_overflow = ov[k];
    end
    step(); cyc++;
    i_start = 1'b0;
    i_valid = 1'b0;
    i_tree_data = '0;
    i_tree_overflow = 1'b0;
    tmo = 1'b0;
    while (!o_valid && !tmo) begin
      if (cyc > 20) tmo = 1'b1;
      else begin step(); cyc++; end
    end
    lat = cyc;
  endtask

  task automatic do_accept();
    i_out_ready = 1'b1;
    step();
    i_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (o_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", o_data); end
    checks++; if ({o_valid, o_ready, o_overflow, o_busy} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {o_valid, o_ready, o_overflow, o_busy}); end
    step();
    i_reset = 1'b0;
    step(); step();
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", o_busy); end
  endtask

  task automatic test_basic();
    int lat; bit tmo;
    run_pixel(3, 7'd3, 32'h2000, 32'h8000, 32'h10000, 32'h4000, 3'b000, lat, tmo);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%0d exp=0", tmo); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL basic_latency got=%0d exp=5", lat); end
    checks++; if (o_data !== 32'h0001E000) begin failures++; $display("FAIL basic_data got=%h exp=0001e000", o_data); end
    checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%b exp=0", o_overflow); end
    do_accept();
    checks++; if ({o_valid, o_busy} !== 2'b00) begin failures++; $display("FAIL basic_idle got=%b exp=00", {o_valid, o_busy}); end
  endtask

  task automatic test_negative();
    int lat; bit tmo; logic [31:0] exp;
`ifdef CONV_ACC_RELU_EN
    exp = 32'h0;
`else
    exp = 32'h80010000;
`endif
    run_pixel(2, 7'd2, 32'h0, 32'h8000, 32'h80018000, 32'h0, 3'b000, lat, tmo);
    checks++; if (tmo !== 1'b0 || lat !== 4) begin failures++; $display("FAIL neg_latency got=%0d tmo=%0d exp=4", lat, tmo); end
    checks++; if (o_data !== exp) begin failures++; $display("FAIL neg_data got=%h exp=%h", o_data, exp); end
    do_accept();
  endtask

  task automatic test_saturation();
    int lat; bit tmo;
    run_pixel(2, 7'd2, 32'h0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 3'b000, lat, tmo);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL sat_timeout got=%0d exp=0", tmo); end
    checks++; if (o_data !== 32'h7FFFFFFF) begin failures++; $display("FAIL sat_data got=%h exp=7fffffff", o_data); end
    checks++; if (o_overflow !== 1'b1) begin failures++; $display("FAIL sat_ovf got=%b exp=1", o_overflow); end
    do_accept();
    checks++; if (o_overflow !== 1'b1) begin failures++; $display("FAIL sat_ovf_hold got=%b exp=1", o_overflow); end
    i_num_channels = 7'd1; i_bias = 32'h0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL sat_ovf_clear got=%b exp=0", o_overflow); end
    i_valid = 1'b1; i_tree_data = 32'h100;
    step();
    i_valid = 1'b0;
    step(); step();
    checks++; if (o_valid !== 1'b1 || o_data !== 32'h100) begin
      failures++; $display("FAIL sat_next_pixel got=%b/%h exp=1/00000100", o_valid, o_data); end
    do_accept();
  endtask

  task automatic test_backpressure();
    int lat; bit tmo;
    run_pixel(1, 7'd1, 32'h1000, 32'h8000, 32'h0, 32'h0, 3'b000, lat, tmo);
    checks++; if (tmo !== 1'b0 || lat !== 3) begin failures++; $display("FAIL bp_latency got=%0d tmo=%0d exp=3", lat, tmo); end
    for (int c = 0; c < 4; c++) begin
      i_start = (c == 1);
      step();
      checks++; if (o_valid !== 1'b1 || o_data !== 32'h9000) begin
        failures++; $display("FAIL bp_hold%0d got=%b/%h exp=1/00009000", c, o_valid, o_data); end
    end
    i_start = 1'b0;
    do_accept();
    checks++; if ({o_valid, o_busy} !== 2'b00) begin failures++; $display("FAIL bp_idle got=%b exp=00", {o_valid, o_busy}); end
  endtask

  task automatic test_enable();
    i_num_channels = 7'd2; i_bias = 32'h0; i_start = 1'b1;
    step();
    i_start = 1'b0; i_enable = 1'b0; i_valid = 1'b1; i_tree_data = 32'h8000;
    #1;
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL en_ready_off got=%b exp=0", o_ready); end
    for (int c = 0; c < 3; c++) step();
    checks++; if (o_busy !== 1'b1 || o_ready !== 1'b0) begin
      failures++; $display("FAIL en_frozen got=%b/%b exp=1/0", o_busy, o_ready); end
    i_enable = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL en_ready_on got=%b exp=1", o_ready); end
    step();
    i_tree_data = 32'h4000;
    step();
    i_valid = 1'b0; i_tree_data = '0;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL en_bias_cycle got=%b exp=0", o_valid); end
    step();
    checks++; if (o_valid !== 1'b1 || o_data !== 32'h0000C000) begin
      failures++; $display("FAIL en_data got=%b/%h exp=1/0000c000", o_valid, o_data); end
    i_enable = 1'b0; i_out_ready = 1'b1;
    step();
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL en_out_gated got=%b exp=1", o_valid); end
    i_enable = 1'b1; i_out_ready = 1'b0;
    do_accept();
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL en_idle got=%b exp=0", o_busy); end
  endtask

  task automatic test_reset_mid();
    int lat; bit tmo;
    i_num_channels = 7'd3; i_bias = 32'h2000; i_start = 1'b1;
    step();
    i_start = 1'b0; i_valid = 1'b1; i_tree_data = 32'h8000; i_tree_overflow = 1'b1;
    step();
    i_tree_overflow = 1'b0; i_tree_data = 32'h10000;
    checks++; if (o_overflow !== 1'b1 || o_busy !== 1'b1) begin
      failures++; $display("FAIL rst_pre got=%b/%b exp=1/1", o_overflow, o_busy); end
    #2 i_reset = 1'b1;
    #1;
    checks++; if ({o_valid, o_ready, o_overflow, o_busy} !== 4'b0000 || o_data !== 32'h0) begin
      failures++; $display("FAIL rst_async got=%b/%h exp=0000/0", {o_valid, o_ready, o_overflow, o_busy}, o_data); end
    i_reset = 1'b0; i_valid = 1'b0; i_tree_data = '0;
    step();
    run_pixel(3, 7'd3, 32'h2000, 32'h8000, 32'h10000, 32'h4000, 3'b000, lat, tmo);
    checks++; if (tmo !== 1'b0 || lat !== 5) begin failures++; $display("FAIL rst_relat got=%0d tmo=%0d exp=5", lat, tmo); end
    checks++; if (o_data !== 32'h0001E000) begin failures++; $display("FAIL rst_redata got=%h exp=0001e000", o_data); end
    do_accept();
  endtask

  task automatic test_zero_channels();
    int lat; bit tmo;
    run_pixel(1, 7'd0, 32'h0, 32'h8000, 32'h0, 32'h0, 3'b001, lat, tmo);
    checks++; if (tmo !== 1'b0 || lat !== 3) begin failures++; $display("FAIL zero_latency got=%0d tmo=%0d exp=3", lat, tmo); end
    checks++; if (o_data !== 32'h8000) begin failures++; $display("FAIL zero_data got=%h exp=00008000", o_data); end
    checks++; if (o_overflow !== 1'b1) begin failures++; $display("FAIL zero_ovf got=%b exp=1", o_overflow); end
    do_accept();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_backpressure();
    test_enable();
    test_reset_mid();
    test_zero_channels();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
